pipeline_control_unit: RTL and testbench



---
 rtl/pipeline_control_unit.sv | 142 ++++++++++++++
 tb/tb_pipeline_control_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_control_unit.sv
// Pipeline sequencer: enables, bubble/flush and forwarding selects for the 4-stage pipe.
// Latency: Moore control one cycle after request, forwarding combinational; holds the pipe during mult/div and load stalls.
module pipeline_control_unit #(
    parameter int MD_CYCLES    = 4,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] haz,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic        md_issue,
    output logic        pc_en,
    output logic        s1_en,
    output logic        s2_en,
    output logic        s2_bubble,
    output logic        s1_flush,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic [1:0]  fwd_br_sel,
    output logic        md_busy,
    output logic        haz_err
);

    if (MD_CYCLES < 2 || MD_CYCLES > 15) begin : g_bad_md_cycles
        $error("MD_CYCLES must be in 2..15");
    end
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 3) begin : g_bad_flush_cycles
        $error("FLUSH_CYCLES must be in 1..3");
    end

    typedef enum logic [1:0] {RUN, LSTALL, MD_WAIT, FLUSH} state_t;

    localparam logic [3:0] MD_INIT = 4'(MD_CYCLES - 2);
    localparam logic [3:0] FL_INIT = 4'(FLUSH_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       pend_q, pend_d;
    logic       haz_err_q, haz_err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            cnt_q     <= 4'd0;
            pend_q    <= 1'b0;
            haz_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            haz_err_q <= haz_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        haz_err_d = haz_err_q;
        case (state_q)
            RUN: begin
                if ((haz[1] && haz[0]) || (haz[6] && haz[4])) haz_err_d = 1'b1;
                if (branch_taken) begin
                    state_d = FLUSH;
                    cnt_d   = FL_INIT;
                end else if (md_issue) begin
                    state_d = MD_WAIT;
                    cnt_d   = MD_INIT;
                end else if (stall) begin
                    state_d = LSTALL;
                end
            end
            LSTALL: state_d = RUN;
            MD_WAIT: begin
                // A branch resolved under the freeze (even on its last cycle) becomes a flush on exit.
                if (cnt_q == 4'd0) begin
                    pend_d = 1'b0;
                    if (pend_q || branch_taken) begin
                        state_d = FLUSH;
                        cnt_d   = FL_INIT;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    cnt_d  = cnt_q - 4'd1;
                    pend_d = pend_q || branch_taken;
                end
            end
            FLUSH: begin
                if (cnt_q == 4'd0) state_d = RUN;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_en      = 1'b1;
        s1_en      = 1'b1;
        s2_en      = 1'b1;
        s2_bubble  = 1'b0;
        s1_flush   = 1'b0;
        md_busy    = 1'b0;
        haz_err    = haz_err_q;
        fwd_a_sel  = 2'b00;
        fwd_b_sel  = 2'b00;
        fwd_br_sel = 2'b00;
        case (state_q)
            LSTALL: begin
                pc_en     = 1'b0;
                s1_en     = 1'b0;
                s2_bubble = 1'b1;
            end
            MD_WAIT: begin
                pc_en   = 1'b0;
                s1_en   = 1'b0;
                s2_en   = 1'b0;
                md_busy = 1'b1;
            end
            FLUSH: begin
                s1_flush  = 1'b1;
                s2_bubble = 1'b1;
            end
            default: ;
        endcase

        // A bubbled ID/EX op has no operands, so never steer its muxes off the regfile.
        if (!s2_bubble) begin
            if (haz[1] || haz[10])               fwd_a_sel = 2'b01;
            else if (haz[0] || haz[8] || haz[9]) fwd_a_sel = 2'b10;

            if (haz[2])      fwd_b_sel = 2'b01;
            else if (haz[3]) fwd_b_sel = 2'b10;

            if (haz[6] || haz[7]) fwd_br_sel = 2'b11;
            else if (haz[4])      fwd_br_sel = 2'b01;
            else if (haz[5])      fwd_br_sel = 2'b10;
        end
    end

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Scoreboard bench: stimulus pushes expected outputs from a cycle-count model, monitor compares on falling edge.
module tb_pipeline_control_unit;

    localparam int MDC = 4;
    localparam int FC  = 2;
    localparam logic [10:0] H_A = 11'b000_0100_0010;
    localparam logic [10:0] H_E = 11'b000_0101_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] haz = '0;
    logic        stall = 1'b0, branch_taken = 1'b0, md_issue = 1'b0;
    logic        pc_en, s1_en, s2_en, s2_bubble, s1_flush, md_busy, haz_err;
    logic [1:0]  fwd_a_sel, fwd_b_sel, fwd_br_sel;

    always #5 clk = ~clk;

    pipeline_control_unit #(.MD_CYCLES(MDC), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .haz(haz), .stall(stall),
        .branch_taken(branch_taken), .md_issue(md_issue),
        .pc_en(pc_en), .s1_en(s1_en), .s2_en(s2_en), .s2_bubble(s2_bubble),
        .s1_flush(s1_flush), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .fwd_br_sel(fwd_br_sel), .md_busy(md_busy), .haz_err(haz_err)
    );

    wire [12:0] dut_vec = {pc_en, s1_en, s2_en, s2_bubble, s1_flush,
                           fwd_a_sel, fwd_b_sel, fwd_br_sel, md_busy, haz_err};

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [12:0] exp_q[$];
    string       tag_q[$];

    // Reference model: remaining frozen / flush cycles rather than a state machine.
    int freeze_left = 0;
    int flush_left  = 0;
    bit lstall_m    = 0;
    bit pend_m      = 0;
    bit err_m       = 0;

    function automatic logic [12:0] model_out(input logic [10:0] h);
        logic pc, s1, s2, bub, fl, busy;
        logic [1:0] a, b, br;
        pc = 1; s1 = 1; s2 = 1; bub = 0; fl = 0; busy = 0;
        if (freeze_left > 0)     begin pc = 0; s1 = 0; s2 = 0; busy = 1; end
        else if (flush_left > 0) begin fl = 1; bub = 1; end
        else if (lstall_m)       begin pc = 0; s1 = 0; bub = 1; end
        a  = (h[1] | h[10]) ? 2'd1 : (h[0] | h[8] | h[9]) ? 2'd2 : 2'd0;
        b  = h[2] ? 2'd1 : h[3] ? 2'd2 : 2'd0;
        br = (h[6] | h[7]) ? 2'd3 : h[4] ? 2'd1 : h[5] ? 2'd2 : 2'd0;
        if (bub) begin a = 0; b = 0; br = 0; end
        return {pc, s1, s2, bub, fl, a, b, br, busy, err_m};
    endfunction

    task automatic model_reset();
        freeze_left = 0; flush_left = 0; lstall_m = 0; pend_m = 0; err_m = 0;
    endtask

    task automatic model_advance(input logic [10:0] h, input logic st, input logic br, input logic md);
        if (freeze_left > 0) begin
            freeze_left--;
            if (br) pend_m = 1;
            if (freeze_left == 0 && pend_m) begin
                flush_left = FC;
                pend_m     = 0;
            end
        end else if (flush_left > 0) begin
            flush_left--;
        end else if (lstall_m) begin
            lstall_m = 0;
        end else begin
            if ((h[1] && h[0]) || (h[6] && h[4])) err_m = 1;
            if (br)       flush_left  = FC;
            else if (md)  freeze_left = MDC - 1;
            else if (st)  lstall_m    = 1;
        end
    endtask

    // Every task entry/exit is one time unit after a rising edge.
    task automatic step(input logic [10:0] h, input logic st, input logic br, input logic md, input string tag);
        haz = h; stall = st; branch_taken = br; md_issue = md;
        exp_q.push_back(model_out(h));
        tag_q.push_back(tag);
        @(posedge clk);
        model_advance(h, st, br, md);
        #1;
    endtask

    task automatic reset_now(input string tag);
        rst = 1; haz = '0; stall = 0; branch_taken = 0; md_issue = 0;
        model_reset();
        exp_q.push_back(model_out('0));
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [12:0] e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_cmp++;
            if (dut_vec !== e) begin
                n_bad++;
                $display("FAIL %s: got %b want %b (pc s1 s2 bub fl a b br busy err)", t, dut_vec, e);
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        reset_now("reset_values");
        step('0, 0, 0, 0, "run_idle");
        step(H_A, 0, 0, 0, "fwd_a_b_run");

        step('0, 1, 0, 0, "stall_req");
        step(H_A, 0, 0, 0, "lstall_bubble");
        step(H_A, 0, 0, 0, "after_lstall");

        step('0, 1, 0, 1, "md_issue");
        for (int i = 0; i < MDC - 1; i++) step('0, 1, 0, 0, "md_freeze");
        step('0, 0, 0, 0, "md_done");

        step('0, 0, 1, 0, "br_taken");
        step('0, 0, 1, 0, "flush_second_br");
        step('0, 0, 0, 0, "flush_last");
        step('0, 0, 0, 0, "run_after_flush");

        step('0, 0, 0, 1, "md_issue_br");
        step('0, 0, 1, 0, "md_br_pulse");
        step('0, 0, 0, 0, "md_freeze_br");
        step('0, 0, 0, 0, "md_freeze_br_last");
        step('0, 0, 0, 0, "pend_flush1");
        step('0, 0, 0, 0, "pend_flush2");
        step('0, 0, 0, 0, "run_after_pend");

        step('0, 0, 0, 1, "md_issue_rst");
        reset_now("rst_mid_md");
        step('0, 0, 0, 0, "post_rst_run");

        step(H_E, 0, 0, 0, "fwd_br_r0");
        step('0, 0, 0, 0, "haz_err_rise");
        step('0, 0, 0, 0, "haz_err_sticky");

        reset_now("reset_before_random");
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199) == 0) begin
                reset_now("rand_reset");
            end else begin
                logic [10:0] h;
                h = 11'($urandom & $urandom & $urandom);
                step(h, $urandom_range(4) == 0, $urandom_range(11) == 0,
                     $urandom_range(9) == 0, "random");
            end
        end

        haz = '0; stall = 0; branch_taken = 0; md_issue = 0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
